// File: rtl/tpu_dma_pkg.sv
`default_nettype none
// ============================================================================
//  tpu_dma_pkg
//  Shared FSM encoding, DMA request field layout and size encodings.
//  Revision: 1.0
// ============================================================================
package tpu_dma_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DATA = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam int c_ctrl_width = 67;
    localparam int c_idx_lsb    = 0;
    localparam int c_idx_width  = 32;
    localparam int c_len_lsb    = 32;
    localparam int c_len_width  = 32;
    localparam int c_size_lsb   = 64;
    localparam int c_size_width = 3;

    localparam logic [2:0] c_size_byte  = 3'b000;
    localparam logic [2:0] c_size_hword = 3'b001;
    localparam logic [2:0] c_size_word  = 3'b010;
    localparam logic [2:0] c_size_dword = 3'b011;

    function automatic logic [c_ctrl_width-1:0] pack_ctrl(
        input logic [c_size_width-1:0] size,
        input logic [c_len_width-1:0]  len,
        input logic [c_idx_width-1:0]  idx
    );
        return {size, len, idx};
    endfunction

endpackage
`default_nettype wire

// File: rtl/dma_burst_loader_if.sv
`default_nettype none
// ============================================================================
//  dma_burst_loader_if
//  DMA read control/channel handshakes plus the BRAM write port.
//  Revision: 1.0
// ============================================================================
interface dma_burst_loader_if #(
    parameter int DMA_DATA_WIDTH = 32,
    parameter int ADDR_WIDTH     = 5,
    parameter int BRAM_INDEX     = 1
);
    import tpu_dma_pkg::*;

    logic                             read_ctrl_valid;
    logic                             read_ctrl_ready;
    logic [c_ctrl_width-1:0]          read_ctrl_data;
    logic                             read_chnl_valid;
    logic                             read_chnl_ready;
    logic [DMA_DATA_WIDTH-1:0]        read_chnl_data;
    logic [BRAM_INDEX+ADDR_WIDTH-1:0] mem_addr;
    logic                             mem_data_valid;
    logic [DMA_DATA_WIDTH-1:0]        mem_data;

    modport master (
        output read_ctrl_valid, read_ctrl_data, read_chnl_ready,
               mem_addr, mem_data_valid, mem_data,
        input  read_ctrl_ready, read_chnl_valid, read_chnl_data
    );

    modport slave (
        input  read_ctrl_valid, read_ctrl_data, read_chnl_ready,
               mem_addr, mem_data_valid, mem_data,
        output read_ctrl_ready, read_chnl_valid, read_chnl_data
    );
endinterface
`default_nettype wire

// File: rtl/bram_addr_gen.sv
`default_nettype none
// ============================================================================
//  bram_addr_gen
//  Placement counters: interleaved round-robin or blocked segments per BRAM.
//  Revision: 1.0
// ============================================================================
module bram_addr_gen #(
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_BRAMS  = 2,
    parameter int BRAM_INDEX = 1
) (
    input  wire logic                             clk,
    input  wire logic                             rst,
    input  wire logic                             clear,
    input  wire logic                             step,
    input  wire logic                             mode,
    input  wire logic [ADDR_WIDTH:0]              seg_len,
    output logic      [BRAM_INDEX+ADDR_WIDTH-1:0] addr
);
    localparam logic [ADDR_WIDTH:0]   c_full_seg = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [BRAM_INDEX-1:0] c_last_sel = BRAM_INDEX'(NUM_BRAMS - 1);

    logic [BRAM_INDEX-1:0] r_bram_sel;
    logic [ADDR_WIDTH-1:0] r_wr_addr;
    logic [ADDR_WIDTH:0]   r_seg_cnt;
    logic [ADDR_WIDTH:0]   w_seg_eff;
    logic                  w_seg_end;

    // seg_cnt is tracked apart from wr_addr because segments longer than the
    // BRAM depth let wr_addr wrap before the segment ends.
    assign w_seg_eff = (seg_len == '0) ? c_full_seg : seg_len;
    assign w_seg_end = (r_seg_cnt == w_seg_eff - 1'b1);
    assign addr      = {r_bram_sel, r_wr_addr};

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_bram_sel <= '0;
            r_wr_addr  <= '0;
            r_seg_cnt  <= '0;
        end else if (step) begin
            if (mode) begin
                if (w_seg_end) begin
                    r_seg_cnt  <= '0;
                    r_wr_addr  <= '0;
                    r_bram_sel <= r_bram_sel + 1'b1;
                end else begin
                    r_seg_cnt  <= r_seg_cnt + 1'b1;
                    r_wr_addr  <= r_wr_addr + 1'b1;
                end
            end else begin
                r_bram_sel <= r_bram_sel + 1'b1;
                if (r_bram_sel == c_last_sel) begin
                    r_wr_addr <= r_wr_addr + 1'b1;
                end
            end
        end
    end
endmodule
`default_nettype wire

// File: rtl/dma_burst_loader.sv
`default_nettype none
// ============================================================================
//  dma_burst_loader
//  Splits a block load into DMA read bursts and scatters beats over BRAMs.
//  Revision: 1.0
// ============================================================================
module dma_burst_loader
    import tpu_dma_pkg::*;
#(
    parameter int         DMA_DATA_WIDTH = 32,
    parameter int         ADDR_WIDTH     = 5,
    parameter int         NUM_BRAMS      = 2,
    parameter int         BRAM_INDEX     = 1,
    parameter int         MAX_BURST      = 16,
    parameter logic [2:0] DMA_SIZE       = c_size_word
) (
    input  wire logic                  clk,
    input  wire logic                  rst,
    input  wire logic                  start_load,
    input  wire logic [31:0]           cfg_base_index,
    input  wire logic [31:0]           cfg_length,
    input  wire logic                  cfg_mode,
    input  wire logic [ADDR_WIDTH:0]   cfg_seg_len,
    output logic                       busy,
    output logic                       done,
    dma_burst_loader_if.master         bus
);
    localparam logic [31:0] c_max_burst = 32'(MAX_BURST);

    state_t                           r_state;
    state_t                           w_next_state;
    logic [31:0]                      r_base;
    logic [31:0]                      r_remaining;
    logic [31:0]                      r_issued;
    logic [31:0]                      r_burst_len;
    logic [31:0]                      r_beat_cnt;
    logic                             r_mode;
    logic [ADDR_WIDTH:0]              r_seg_len;
    logic                             w_start;
    logic                             w_ctrl_fire;
    logic                             w_beat;
    logic                             w_last_beat;
    logic [31:0]                      w_req_len;
    logic [BRAM_INDEX+ADDR_WIDTH-1:0] w_addr;

    assign w_start     = (r_state == S_IDLE) && start_load;
    assign w_ctrl_fire = (r_state == S_REQ) && bus.read_ctrl_ready;
    assign w_beat      = (r_state == S_DATA) && bus.read_chnl_valid;
    assign w_last_beat = w_beat && (r_beat_cnt == r_burst_len - 32'd1);
    assign w_req_len   = (r_remaining > c_max_burst) ? c_max_burst : r_remaining;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state        = r_state;
        busy                = 1'b0;
        done                = 1'b0;
        bus.read_ctrl_valid = 1'b0;
        bus.read_ctrl_data  = '0;
        bus.read_chnl_ready = 1'b0;
        bus.mem_data_valid  = 1'b0;
        bus.mem_data        = {DMA_DATA_WIDTH{1'b0}};
        bus.mem_addr        = {(BRAM_INDEX + ADDR_WIDTH){1'b0}};
        case (r_state)
            S_IDLE: begin
                if (start_load) begin
                    w_next_state = (cfg_length == 32'd0) ? S_DONE : S_REQ;
                end
            end
            S_REQ: begin
                busy                = 1'b1;
                bus.read_ctrl_valid = 1'b1;
                bus.read_ctrl_data  = pack_ctrl(DMA_SIZE, w_req_len, r_base + r_issued);
                if (bus.read_ctrl_ready) begin
                    w_next_state = S_DATA;
                end
            end
            S_DATA: begin
                busy                = 1'b1;
                bus.read_chnl_ready = 1'b1;
                if (bus.read_chnl_valid) begin
                    bus.mem_data_valid = 1'b1;
                    bus.mem_data       = bus.read_chnl_data;
                    bus.mem_addr       = w_addr;
                end
                if (w_last_beat) begin
                    w_next_state = (r_remaining == 32'd1) ? S_DONE : S_REQ;
                end
            end
            S_DONE: begin
                done         = 1'b1;
                w_next_state = S_IDLE;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // Configuration is captured once; later cfg_* activity never reaches the datapath.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_base      <= '0;
            r_remaining <= '0;
            r_issued    <= '0;
            r_burst_len <= '0;
            r_beat_cnt  <= '0;
            r_mode      <= 1'b0;
            r_seg_len   <= '0;
        end else begin
            if (w_start) begin
                r_base      <= cfg_base_index;
                r_remaining <= cfg_length;
                r_issued    <= '0;
                r_burst_len <= '0;
                r_beat_cnt  <= '0;
                r_mode      <= cfg_mode;
                r_seg_len   <= cfg_seg_len;
            end
            if (w_ctrl_fire) begin
                r_burst_len <= w_req_len;
                r_issued    <= r_issued + w_req_len;
                r_beat_cnt  <= '0;
            end
            if (w_beat) begin
                r_beat_cnt  <= r_beat_cnt + 32'd1;
                r_remaining <= r_remaining - 32'd1;
            end
        end
    end

    bram_addr_gen #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .NUM_BRAMS  (NUM_BRAMS),
        .BRAM_INDEX (BRAM_INDEX)
    ) u_addr_gen (
        .clk     (clk),
        .rst     (rst),
        .clear   (w_start),
        .step    (w_beat),
        .mode    (r_mode),
        .seg_len (r_seg_len),
        .addr    (w_addr)
    );
endmodule
`default_nettype wire

// File: tb/tb_dma_burst_loader.sv
`default_nettype none
// ============================================================================
//  tb_dma_burst_loader
//  Scoreboard bench: DMA responder, expected-transaction queues, monitor.
//  Revision: 1.0
// ============================================================================
module tb_dma_burst_loader;
    import tpu_dma_pkg::*;

    localparam logic [31:0] c_key = 32'h5A5A_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_load = 1'b0;
    logic [31:0] cfg_base_index = '0;
    logic [31:0] cfg_length = '0;
    logic        cfg_mode = 1'b0;
    logic [5:0]  cfg_seg_len = '0;
    logic        busy, done;

    dma_burst_loader_if #(.DMA_DATA_WIDTH(32), .ADDR_WIDTH(5), .BRAM_INDEX(1)) bus ();

    dma_burst_loader #(
        .DMA_DATA_WIDTH(32), .ADDR_WIDTH(5), .NUM_BRAMS(2), .BRAM_INDEX(1),
        .MAX_BURST(16), .DMA_SIZE(3'b010)
    ) dut (
        .clk(clk), .rst(rst), .start_load(start_load),
        .cfg_base_index(cfg_base_index), .cfg_length(cfg_length),
        .cfg_mode(cfg_mode), .cfg_seg_len(cfg_seg_len),
        .busy(busy), .done(done), .bus(bus)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int done_cnt = 0;
    int wr_seen = 0;

    logic [66:0] exp_req[$];
    logic [37:0] exp_wr[$];

    int  stall_cycles = 0;
    bit  throttle = 1'b0;
    bit  eager = 1'b0;
    int  beat_budget = 1000000;

    task automatic chk(input string name, input logic [66:0] got, input logic [66:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, want);
        end
    endtask

    task automatic push_req(input logic [31:0] idx, input logic [31:0] len);
        exp_req.push_back({3'b010, len, idx});
    endtask

    task automatic push_wr(input logic [5:0] addr, input logic [31:0] word_idx);
        exp_wr.push_back({addr, word_idx ^ c_key});
    endtask

    function automatic logic [5:0] ilv_addr(input int k);
        return 6'(((k % 2) << 5) | ((k / 2) % 32));
    endfunction

    function automatic logic [5:0] blk_addr(input int k, input int seg);
        return 6'((((k / seg) % 2) << 5) | ((k % seg) % 32));
    endfunction

    // DMA responder: grants requests after a programmable stall, then streams
    // beats whose payload is the word index scrambled by c_key.
    initial begin : responder
        logic [31:0] bq_idx[$];
        logic [31:0] bq_len[$];
        logic [31:0] cur_idx;
        logic [31:0] cur_left;
        int          wait_cnt;
        cur_idx  = '0;
        cur_left = '0;
        wait_cnt = 0;
        bus.read_ctrl_ready = 1'b0;
        bus.read_chnl_valid = 1'b0;
        bus.read_chnl_data  = '0;
        forever begin
            @(posedge clk); #1;
            if (bus.read_ctrl_valid) begin
                if (wait_cnt < stall_cycles) begin
                    bus.read_ctrl_ready = 1'b0;
                    wait_cnt++;
                end else begin
                    bus.read_ctrl_ready = 1'b1;
                    wait_cnt = 0;
                end
            end else begin
                bus.read_ctrl_ready = 1'b0;
            end
            if (cur_left == 0 && bq_idx.size() > 0) begin
                cur_idx  = bq_idx.pop_front();
                cur_left = bq_len.pop_front();
            end
            if (cur_left != 0 && beat_budget > 0) begin
                bus.read_chnl_valid = throttle ? ($urandom_range(0, 2) != 0) : 1'b1;
                bus.read_chnl_data  = cur_idx ^ c_key;
            end else if (eager) begin
                bus.read_chnl_valid = 1'b1;
                bus.read_chnl_data  = 32'hDEAD_BEEF;
            end else begin
                bus.read_chnl_valid = 1'b0;
                bus.read_chnl_data  = '0;
            end
            @(negedge clk);
            if (rst) begin
                bq_idx.delete();
                bq_len.delete();
                cur_left = '0;
                wait_cnt = 0;
            end else begin
                if (bus.read_ctrl_valid && bus.read_ctrl_ready) begin
                    bq_idx.push_back(bus.read_ctrl_data[31:0]);
                    bq_len.push_back(bus.read_ctrl_data[63:32]);
                end
                if (bus.read_chnl_valid && bus.read_chnl_ready && cur_left != 0) begin
                    cur_idx++;
                    cur_left--;
                    beat_budget--;
                end
            end
        end
    end

    initial begin : monitor
        bit          prev_wait;
        bit          prev_done;
        logic [66:0] prev_data;
        prev_wait = 1'b0;
        prev_done = 1'b0;
        prev_data = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_wait = 1'b0;
                prev_done = 1'b0;
            end else begin
                if (prev_wait) begin
                    chk("req_valid_held", 67'(bus.read_ctrl_valid), 67'd1);
                    chk("req_fields_held", bus.read_ctrl_data, prev_data);
                end
                if (bus.read_ctrl_valid) begin
                    chk("chnl_ready_in_req", 67'(bus.read_chnl_ready), 67'd0);
                    if (bus.read_ctrl_ready) begin
                        if (exp_req.size() == 0) chk("unexpected_req", bus.read_ctrl_data, 67'd0);
                        else chk("req_fields", bus.read_ctrl_data, exp_req.pop_front());
                    end
                end
                if (bus.mem_data_valid) begin
                    wr_seen++;
                    chk("wr_on_accepted_beat", 67'(bus.read_chnl_valid && bus.read_chnl_ready), 67'd1);
                    if (exp_wr.size() == 0) chk("unexpected_wr", 67'({bus.mem_addr, bus.mem_data}), 67'd0);
                    else chk("wr_addr_data", 67'({bus.mem_addr, bus.mem_data}), 67'(exp_wr.pop_front()));
                end
                if (done) begin
                    done_cnt++;
                    if (prev_done) chk("done_single_cycle", 67'd1, 67'd0);
                end
                prev_wait = bus.read_ctrl_valid && !bus.read_ctrl_ready;
                prev_data = bus.read_ctrl_data;
                prev_done = done;
            end
        end
    end

    task automatic do_start(input logic [31:0] base, input logic [31:0] len,
                            input logic mode, input logic [5:0] seg);
        @(posedge clk); #1;
        start_load     = 1'b1;
        cfg_base_index = base;
        cfg_length     = len;
        cfg_mode       = mode;
        cfg_seg_len    = seg;
        @(posedge clk); #1;
        start_load     = 1'b0;
        cfg_base_index = 32'hBAD0_0000;
        cfg_length     = 32'd3;
        cfg_mode       = ~mode;
        cfg_seg_len    = 6'd1;
    endtask

    task automatic finish_load(input string name);
        int start_cnt;
        int n;
        start_cnt = done_cnt;
        n = 0;
        while (done_cnt == start_cnt && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) chk({name, "_done_timeout"}, 67'd1, 67'd0);
        repeat (3) @(negedge clk);
        chk({name, "_done_count"}, 67'(done_cnt - start_cnt), 67'd1);
        chk({name, "_req_drained"}, 67'(exp_req.size()), 67'd0);
        chk({name, "_wr_drained"}, 67'(exp_wr.size()), 67'd0);
    endtask

    initial begin : stimulus
        logic [5:0] t1_addr [8];
        int n;
        int base_done;
        t1_addr = '{6'h00, 6'h20, 6'h01, 6'h21, 6'h02, 6'h22, 6'h03, 6'h23};

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_busy", 67'(busy), 67'd0);
        chk("rst_done", 67'(done), 67'd0);
        chk("rst_ctrl_valid", 67'(bus.read_ctrl_valid), 67'd0);
        chk("rst_chnl_ready", 67'(bus.read_chnl_ready), 67'd0);
        chk("rst_mem_valid", 67'(bus.mem_data_valid), 67'd0);
        chk("rst_mem_addr_data", 67'({bus.mem_addr, bus.mem_data}), 67'd0);

        // Single burst, interleaved
        push_req(32'h100, 32'd8);
        for (int k = 0; k < 8; k++) push_wr(t1_addr[k], 32'h100 + k);
        do_start(32'h100, 32'd8, 1'b0, 6'd0);
        finish_load("single");

        // Three bursts; junk beats are offered while the loader sits in REQ
        eager = 1'b1;
        push_req(32'h2000, 32'd16);
        push_req(32'h2010, 32'd16);
        push_req(32'h2020, 32'd8);
        for (int k = 0; k < 40; k++) push_wr(ilv_addr(k), 32'h2000 + k);
        do_start(32'h2000, 32'd40, 1'b0, 6'd0);
        finish_load("multi");
        eager = 1'b0;

        // Blocked, six beats per BRAM
        push_req(32'h500, 32'd12);
        for (int k = 0; k < 12; k++) push_wr(blk_addr(k, 6), 32'h500 + k);
        do_start(32'h500, 32'd12, 1'b1, 6'd6);
        finish_load("blocked");

        // Blocked with seg_len 0 meaning a full 32-word segment
        push_req(32'h800, 32'd16);
        push_req(32'h810, 32'd16);
        push_req(32'h820, 32'd2);
        for (int k = 0; k < 34; k++) push_wr(blk_addr(k, 32), 32'h800 + k);
        do_start(32'h800, 32'd34, 1'b1, 6'd0);
        finish_load("blocked_full");

        // Backpressure, index wrap past 2^32, and a start pulse during DATA
        stall_cycles = 5;
        throttle     = 1'b1;
        push_req(32'hFFFF_FFF8, 32'd16);
        push_req(32'h0000_0008, 32'd4);
        for (int k = 0; k < 20; k++) push_wr(ilv_addr(k), 32'hFFFF_FFF8 + k);
        do_start(32'hFFFF_FFF8, 32'd20, 1'b0, 6'd0);
        n = 0;
        while (!bus.read_chnl_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk("bp_reach_data_timeout", 67'd1, 67'd0);
        @(posedge clk); #1;
        start_load     = 1'b1;
        cfg_base_index = 32'h123;
        cfg_length     = 32'd5;
        @(posedge clk); #1;
        start_load     = 1'b0;
        finish_load("backpressure");
        stall_cycles = 0;
        throttle     = 1'b0;

        // Zero length: done in the cycle after the start cycle, no request
        @(posedge clk); #1;
        start_load  = 1'b1;
        cfg_length  = 32'd0;
        cfg_base_index = 32'h40;
        @(negedge clk);
        chk("zero_done_start_cycle", 67'(done), 67'd0);
        @(posedge clk); #1;
        start_load = 1'b0;
        @(negedge clk);
        chk("zero_done_pulse", 67'(done), 67'd1);
        chk("zero_no_request", 67'(bus.read_ctrl_valid), 67'd0);
        @(negedge clk);
        chk("zero_done_cleared", 67'(done), 67'd0);
        repeat (3) @(negedge clk);

        // Reset after three beats of an eight-beat burst
        beat_budget = 3;
        push_req(32'h300, 32'd8);
        for (int k = 0; k < 3; k++) push_wr(ilv_addr(k), 32'h300 + k);
        do_start(32'h300, 32'd8, 1'b0, 6'd0);
        n = 0;
        while (wr_seen < 3 + 8 + 40 + 12 + 34 + 20 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk("rst_mid_beats_timeout", 67'd1, 67'd0);
        base_done = done_cnt;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        beat_budget = 1000000;
        @(negedge clk);
        chk("midrst_busy", 67'(busy), 67'd0);
        chk("midrst_ctrl_valid", 67'(bus.read_ctrl_valid), 67'd0);
        chk("midrst_chnl_ready", 67'(bus.read_chnl_ready), 67'd0);
        chk("midrst_mem", 67'({bus.mem_data_valid, bus.mem_addr, bus.mem_data}), 67'd0);
        repeat (5) @(negedge clk);
        chk("midrst_no_done", 67'(done_cnt - base_done), 67'd0);
        chk("midrst_wr_drained", 67'(exp_wr.size()), 67'd0);

        push_req(32'h40, 32'd4);
        for (int k = 0; k < 4; k++) push_wr(ilv_addr(k), 32'h40 + k);
        do_start(32'h40, 32'd4, 1'b0, 6'd0);
        finish_load("after_rst");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got hang, expected completion");
        $fatal(1, "watchdog");
    end
endmodule
`default_nettype wire
